mod_exp_seq: RTL and testbench
==============================

Name: mod_exp_seq

Overview:
Parametrised sequential modular exponentiation engine that computes result = base^exponent mod modulus. It is the next-generation replacement for the fixed-width exponentiation datapath inside the RSA control block, and serves both encryption (e) and decryption (d).
- Operand width and exponent width are independent parameters.
- Uses left-to-right square-and-multiply over a bit-serial interleaved (Blakley) modular multiplier.
- Adds a start/busy/done handshake, base pre-reduction, leading-zero skip and error flagging.

Parameters:
WIDTH, 128, bit width of base, modulus and result.
EXP_WIDTH, 128, bit width of exponent.

Ports:
clk  input  1  rising-edge clock, single clock domain.
reset  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when busy=0.
base  input  WIDTH  message or ciphertext; any value, may be >= modulus.
exponent  input  EXP_WIDTH  e or d.
modulus  input  WIDTH  n.
busy  output  1  high from the cycle after start is accepted through the done cycle.
done  output  1  one-cycle pulse; result valid.
result  output  WIDTH  base^exponent mod modulus; held until next accepted start or reset.
error  output  1  set with done when modulus==0; cleared on next accepted start.

Behaviour:
- Reset: on any edge with reset=1, the FSM goes to IDLE and busy=0, done=0, error=0, result=0. This applies mid-operation too; the in-flight job is discarded.
- Reset has priority over start.
- Inputs are captured into internal registers on the accept edge (start=1, busy=0). Input changes after that have no effect.
- start while busy=1 is ignored. No queueing.

- Modmul unit (a*b mod n, requires b<n):
  - r starts at 0.
  - For i = WIDTH-1 down to 0: r = 2r + a[i]*b, then subtract n at most twice so that r<n.
  - One bit per cycle, exactly WIDTH cycles.
  - Internal r register is WIDTH+2 bits.

- States and cycle occupancy:
  - IDLE: waits for accept.
  - LOAD (1 cycle):
    - modulus==0 -> DONE with error=1, result=0.
    - modulus==1 -> DONE with result=0.
    - otherwise -> REDUCE.
  - REDUCE (WIDTH cycles): breduced = modmul(base, 1).
  - SCAN (1 cycle per exponent bit examined, starting at MSB):
    - Zero bit: decrement the index.
    - First 1 found at index m: acc = breduced, go to SQUARE if m>0, else DONE.
    - Exponent==0: EXP_WIDTH cycles, then DONE with result=1.
  - SQUARE (WIDTH cycles): acc = acc*acc mod n. Next bit = 1 -> MUL; otherwise move to the next bit, or DONE if it was bit 0.
  - MUL (WIDTH cycles): acc = acc*breduced mod n. Then move to the next bit, or DONE if it was bit 0.
  - DONE (1 cycle): done=1, busy=1, result=acc. Then IDLE; busy drops on the following edge.

- Busy cycles, normal path: with m = MSB index and h = number of ones below m, total = 1 + WIDTH + (EXP_WIDTH-m) + m*WIDTH + h*WIDTH + 1.
- Busy cycles, exponent==0: 1 + WIDTH + EXP_WIDTH + 1.
- Busy cycles, modulus 0 or 1: 2.
- start may be asserted in the cycle after done; it is accepted because busy=0 then.
- No combinational path from inputs to outputs.

Test Plan:
- WIDTH=16, EXP_WIDTH=16; base=4, exponent=13, modulus=497 -> result=445, done exactly 111 busy cycles after accept, error=0.
- WIDTH=128; base=65, exponent=17, modulus=3233 -> 2790. Then base=2790, exponent=2753, modulus=3233 -> 65 (encrypt/decrypt round-trip).
- base=500, exponent=1, modulus=497 -> 3 (pre-reduction). exponent=0, modulus=497 -> 1. modulus=1 -> 0 after 2 busy cycles.
- modulus=0 -> done with error=1, result=0. Next valid start clears error.
- Start pulse asserted mid-job with different operands -> ignored; first job's result unchanged.
- reset=1 during SQUARE of a long job -> busy=0, result=0 next cycle, no done pulse. Subsequent start completes correctly.

Source files
------------

// File: rtl/mod_exp_seq_if.sv
// Request/response bundle for the modular exponentiation engine.
// The master drives operands and start; the slave (engine) returns status and result.
interface mod_exp_seq_if #(
   parameter int WIDTH     = 128,
   parameter int EXP_WIDTH = 128
);
   logic                 start;
   logic [WIDTH-1:0]     base;
   logic [EXP_WIDTH-1:0] exponent;
   logic [WIDTH-1:0]     modulus;
   logic                 busy;
   logic                 done;
   logic [WIDTH-1:0]     result;
   logic                 error;

   modport master (
      output start, base, exponent, modulus,
      input  busy, done, result, error
   );

   modport slave (
      input  start, base, exponent, modulus,
      output busy, done, result, error
   );
endinterface

// File: rtl/mod_exp_seq.sv
// Sequential base^exponent mod modulus: left-to-right square-and-multiply on top of
// a bit-serial interleaved modular multiplier that is shared by every step.
module mod_exp_seq #(
   parameter int WIDTH     = 128,
   parameter int EXP_WIDTH = 128
) (
   input  logic          clk,
   input  logic          reset,
   mod_exp_seq_if.slave  bus
);
   localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, REDUCE, SCAN, SQUARE, MUL, DONE} state_t;

   state_t               state;
   logic [WIDTH-1:0]     base_r, mod_r, bred, mm_a, mm_b;
   logic [EXP_WIDTH-1:0] exp_r;
   logic [IW-1:0]        idx;
   logic [CW-1:0]        cnt;
   logic [WIDTH+1:0]     r, t1, t2, t3, n_ext;
   logic                 mm_last;

   // One multiplier step: r < n and b < n keep 2r+b below 3n, so two trial
   // subtractions always land back in [0, n).
   always_comb begin
      n_ext   = {2'b00, mod_r};
      t1      = (r << 1) + (mm_a[WIDTH-1] ? {2'b00, mm_b} : '0);
      t2      = (t1 >= n_ext) ? t1 - n_ext : t1;
      t3      = (t2 >= n_ext) ? t2 - n_ext : t2;
      mm_last = (cnt == CW'(WIDTH-1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         bus.busy   <= 1'b0;
         bus.done   <= 1'b0;
         bus.error  <= 1'b0;
         bus.result <= '0;
      end else begin
         if (state == REDUCE || state == SQUARE || state == MUL) begin
            r    <= t3[WIDTH+1:0];
            mm_a <= mm_a << 1;
            cnt  <= cnt + 1'b1;
         end
         case (state)
            IDLE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  base_r    <= bus.base;
                  exp_r     <= bus.exponent;
                  mod_r     <= bus.modulus;
                  bus.error <= 1'b0;
                  bus.busy  <= 1'b1;
                  state     <= LOAD;
               end
            end
            LOAD: begin
               idx <= IW'(EXP_WIDTH-1);
               if (mod_r == '0 || mod_r == WIDTH'(1)) begin
                  bus.error  <= (mod_r == '0);
                  bus.result <= '0;
                  bus.done   <= 1'b1;
                  state      <= DONE;
               end else begin
                  // base mod n via base*1, so oversized bases need no divider
                  r     <= '0;
                  cnt   <= '0;
                  mm_a  <= base_r;
                  mm_b  <= WIDTH'(1);
                  state <= REDUCE;
               end
            end
            REDUCE: begin
               if (mm_last) begin
                  bred  <= t3[WIDTH-1:0];
                  state <= SCAN;
               end
            end
            SCAN: begin
               if (exp_r[idx]) begin
                  if (idx == '0) begin
                     bus.result <= bred;
                     bus.done   <= 1'b1;
                     state      <= DONE;
                  end else begin
                     idx   <= idx - 1'b1;
                     r     <= '0;
                     cnt   <= '0;
                     mm_a  <= bred;
                     mm_b  <= bred;
                     state <= SQUARE;
                  end
               end else if (idx == '0) begin
                  bus.result <= WIDTH'(1);
                  bus.done   <= 1'b1;
                  state      <= DONE;
               end else begin
                  idx <= idx - 1'b1;
               end
            end
            SQUARE: begin
               // idx already names the bit that this square is consuming
               if (mm_last) begin
                  r   <= '0;
                  cnt <= '0;
                  if (exp_r[idx]) begin
                     mm_a  <= t3[WIDTH-1:0];
                     mm_b  <= bred;
                     state <= MUL;
                  end else if (idx == '0) begin
                     bus.result <= t3[WIDTH-1:0];
                     bus.done   <= 1'b1;
                     state      <= DONE;
                  end else begin
                     idx  <= idx - 1'b1;
                     mm_a <= t3[WIDTH-1:0];
                     mm_b <= t3[WIDTH-1:0];
                  end
               end
            end
            MUL: begin
               if (mm_last) begin
                  r   <= '0;
                  cnt <= '0;
                  if (idx == '0) begin
                     bus.result <= t3[WIDTH-1:0];
                     bus.done   <= 1'b1;
                     state      <= DONE;
                  end else begin
                     idx   <= idx - 1'b1;
                     mm_a  <= t3[WIDTH-1:0];
                     mm_b  <= t3[WIDTH-1:0];
                     state <= SQUARE;
                  end
               end
            end
            DONE: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mod_exp_seq.sv
// Self-checking bench: a 16-bit and a 128-bit engine driven from a vector table
// through an expected-result queue, plus hand sequences for ignored start and reset.
module tb_mod_exp_seq;
   logic clk, reset;

   mod_exp_seq_if #(.WIDTH(16),  .EXP_WIDTH(16))  b16();
   mod_exp_seq_if #(.WIDTH(128), .EXP_WIDTH(128)) b128();

   mod_exp_seq #(.WIDTH(16),  .EXP_WIDTH(16))  d16  (.clk(clk), .reset(reset), .bus(b16));
   mod_exp_seq #(.WIDTH(128), .EXP_WIDTH(128)) d128 (.clk(clk), .reset(reset), .bus(b128));

   typedef struct {
      logic [127:0] b, e, m, r;
      logic         err;
      int           cyc;
      bit           w16;
   } vec_t;

   vec_t sb[$];
   vec_t tab[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic int cyc_of(input int w, input int ew, input logic [127:0] e, input logic [127:0] m);
      int msb, h;
      msb = -1; h = 0;
      if (m < 2) return 2;
      for (int i = 0; i < ew; i++) if (e[i]) msb = i;
      if (msb < 0) return 1 + w + ew + 1;
      for (int i = 0; i < msb; i++) if (e[i]) h++;
      return 1 + w + (ew - msb) + msb * w + h * w + 1;
   endfunction

   // Right-to-left reference, small operands only
   function automatic logic [127:0] mexp(input longint unsigned b, input longint unsigned e, input longint unsigned m);
      longint unsigned r;
      if (m == 0) return 0;
      r = 1 % m; b = b % m;
      while (e != 0) begin
         if (e[0]) r = (r * b) % m;
         b = (b * b) % m;
         e = e >> 1;
      end
      return 128'(r);
   endfunction

   function automatic vec_t mk(input logic [127:0] b, e, m, r, input logic err, input bit w16);
      vec_t v;
      v.b = b; v.e = e; v.m = m; v.r = r; v.err = err; v.w16 = w16;
      v.cyc = w16 ? cyc_of(16, 16, e, m) : cyc_of(128, 128, e, m);
      return v;
   endfunction

   task automatic drive(input bit w16, input logic [127:0] b, e, m, input logic s);
      if (w16) begin
         b16.base = b[15:0]; b16.exponent = e[15:0]; b16.modulus = m[15:0]; b16.start = s;
      end else begin
         b128.base = b; b128.exponent = e; b128.modulus = m; b128.start = s;
      end
   endtask

   task automatic sample(input bit w16, output logic [127:0] res, output logic bsy, dn, er);
      if (w16) begin
         res = 128'(b16.result); bsy = b16.busy; dn = b16.done; er = b16.error;
      end else begin
         res = b128.result; bsy = b128.busy; dn = b128.done; er = b128.error;
      end
   endtask

   // Launch one job, scramble the operand pins after accept, optionally pulse a
   // competing start at busy cycle inj, then compare against the queued expectation.
   task automatic run(input vec_t v, input int inj);
      logic [127:0] res;
      logic bsy, dn, er;
      int   cnt;
      bit   got;
      vec_t e;
      @(negedge clk);
      drive(v.w16, v.b, v.e, v.m, 1'b1);
      @(posedge clk); #1;
      drive(v.w16, ~v.b, ~v.e, ~v.m, 1'b0);
      sb.push_back(v);
      cnt = 0; got = 0;
      for (int c = 0; c < 6000 && !got; c++) begin
         @(negedge clk);
         sample(v.w16, res, bsy, dn, er);
         if (c == 0) chk("err_clr_on_start", 128'(er), 128'(0));
         if (inj >= 0 && c == inj) drive(v.w16, 128'd7, 128'd3, 128'd11, 1'b1);
         else if (inj >= 0 && c == inj + 1) drive(v.w16, ~v.b, ~v.e, ~v.m, 1'b0);
         if (bsy) cnt++;
         if (dn) begin
            got = 1;
            e = sb.pop_front();
            chk("result", res, e.r);
            chk("error", 128'(er), 128'(e.err));
            chk("busy_cycles", 128'(cnt), 128'(e.cyc));
         end
      end
      chk("done_seen", 128'(got), 128'(1));
      if (!got) sb.delete();
      @(negedge clk);
      sample(v.w16, res, bsy, dn, er);
      chk("busy_drop", 128'(bsy), 128'(0));
      chk("done_pulse", 128'(dn), 128'(0));
   endtask

   initial begin
      logic [127:0] res;
      logic bsy, dn, er;
      bit   saw;
      vec_t v;
      logic [127:0] rb, re, rm;

      reset = 1'b1;
      drive(1'b1, '0, '0, '0, 1'b0);
      drive(1'b0, '0, '0, '0, 1'b0);
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         sample(k == 1, res, bsy, dn, er);
         chk("rst_busy", 128'(bsy), 128'(0));
         chk("rst_done", 128'(dn), 128'(0));
         chk("rst_error", 128'(er), 128'(0));
         chk("rst_result", res, 128'(0));
      end
      reset = 1'b0;

      v = mk(128'd4, 128'd13, 128'd497, 128'd445, 1'b0, 1'b1);
      v.cyc = 111;
      tab.push_back(v);
      tab.push_back(mk(128'd65,   128'd17,   128'd3233, 128'd2790, 1'b0, 1'b0));
      tab.push_back(mk(128'd2790, 128'd2753, 128'd3233, 128'd65,   1'b0, 1'b0));
      tab.push_back(mk(128'd500,  128'd1,    128'd497,  128'd3,    1'b0, 1'b0));
      tab.push_back(mk(128'd77,   128'd0,    128'd497,  128'd1,    1'b0, 1'b0));
      tab.push_back(mk(128'd123,  128'd5,    128'd1,    128'd0,    1'b0, 1'b0));
      tab.push_back(mk(128'd123,  128'd5,    128'd0,    128'd0,    1'b1, 1'b0));
      tab.push_back(mk(128'd9,    128'd3,    128'd1000, 128'd729,  1'b0, 1'b0));
      tab.push_back(mk(128'd3,    128'd5,    128'd7,    128'd5,    1'b0, 1'b0));
      tab.push_back(mk(128'd1 << 100, 128'd1, 128'd3,   128'd1,    1'b0, 1'b0));
      tab.push_back(mk((128'd1 << 127) + 128'd5, 128'd1, 128'd1 << 127, 128'd5, 1'b0, 1'b0));
      tab.push_back(mk(128'd2,    128'd127,  ~128'd0,   128'd1 << 127, 1'b0, 1'b0));
      tab.push_back(mk(~128'd0,   128'd3,    ~128'd0,   128'd0,    1'b0, 1'b0));
      tab.push_back(mk(128'd500,  128'd1,    128'd0,    128'd0,    1'b1, 1'b1));
      tab.push_back(mk(128'd500,  128'd0,    128'd497,  128'd1,    1'b0, 1'b1));
      for (int k = 0; k < 6; k++) begin
         rb = 128'($urandom_range(0, 65535));
         re = 128'($urandom_range(0, 65535));
         rm = 128'($urandom_range(2, 65535));
         tab.push_back(mk(rb, re, rm, mexp(64'(rb), 64'(re), 64'(rm)), 1'b0, 1'b1));
      end
      for (int i = 0; i < tab.size(); i++) run(tab[i], -1);

      // competing start mid-job must be dropped
      run(mk(128'd65, 128'd17, 128'd3233, 128'd2790, 1'b0, 1'b0), 40);

      // reset during a square of a long job
      @(negedge clk);
      drive(1'b0, 128'd2790, 128'd2753, 128'd3233, 1'b1);
      @(posedge clk); #1;
      drive(1'b0, '0, '0, '0, 1'b0);
      repeat (300) @(negedge clk);
      sample(1'b0, res, bsy, dn, er);
      chk("mid_job_busy", 128'(bsy), 128'(1));
      reset = 1'b1;
      @(posedge clk); #1;
      sample(1'b0, res, bsy, dn, er);
      chk("abort_busy", 128'(bsy), 128'(0));
      chk("abort_done", 128'(dn), 128'(0));
      chk("abort_result", res, 128'(0));
      @(negedge clk);
      reset = 1'b0;
      saw = 0;
      repeat (8) begin
         @(negedge clk);
         sample(1'b0, res, bsy, dn, er);
         if (dn || bsy) saw = 1;
      end
      chk("abort_quiet", 128'(saw), 128'(0));
      run(mk(128'd2790, 128'd2753, 128'd3233, 128'd65, 1'b0, 1'b0), -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
